// File: rtl/uart_rx_deserializer_if.sv
// Bus bundle between the UART receive line side and the downstream parity checker.
// slave is the receiver (the deserializer), master is whoever drives the line and consumes frames.
interface uart_rx_deserializer_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  baud_tick;
  logic                  rxd;
  logic                  parity_en;
  logic [DATA_WIDTH:0]   data_in_parity;
  logic                  rx_valid;
  logic                  framing_err;
  logic                  rx_busy;

  modport master (
    output baud_tick, rxd, parity_en,
    input  data_in_parity, rx_valid, framing_err, rx_busy
  );

  modport slave (
    input  baud_tick, rxd, parity_en,
    output data_in_parity, rx_valid, framing_err, rx_busy
  );
endinterface

// File: rtl/uart_rx_deserializer.sv
// Oversampled UART receiver: start-bit qualification, LSB-first data, optional parity bit,
// stop-bit framing check and a break state that holds off reception while the line stays low.
module uart_rx_deserializer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  uart_rx_deserializer_if.slave bus
);

  localparam int unsigned CNT_W = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam int unsigned BIT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  // Start qualification happens on the tick that brings the counter to OVERSAMPLE/2-1.
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 2);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

  state_t                state_q, state_n;
  logic                  rxd_m, rxd_s;
  logic [CNT_W-1:0]      cnt_q, cnt_n;
  logic [BIT_W-1:0]      bit_q, bit_n;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_n;
  logic                  par_q, par_n;
  logic                  par_en_q, par_en_n;
  logic                  stop_q, stop_n;
  logic                  pend_q, pend_n;
  logic [DATA_WIDTH:0]   dout_q;
  logic                  valid_q;
  logic                  ferr_q;
  logic                  busy_q;

  // Synchronizer, FSM state and registered outputs.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      rxd_m    <= 1'b1;
      rxd_s    <= 1'b1;
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      par_q    <= 1'b0;
      par_en_q <= 1'b0;
      stop_q   <= 1'b1;
      pend_q   <= 1'b0;
      dout_q   <= '0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      rxd_m    <= bus.rxd;
      rxd_s    <= rxd_m;
      state_q  <= state_n;
      cnt_q    <= cnt_n;
      bit_q    <= bit_n;
      shreg_q  <= shreg_n;
      par_q    <= par_n;
      par_en_q <= par_en_n;
      stop_q   <= stop_n;
      pend_q   <= pend_n;
      valid_q  <= pend_q;
      busy_q   <= (state_n != IDLE);
      if (pend_q) begin
        dout_q <= {par_q, shreg_q};
        ferr_q <= ~stop_q;
      end
    end
  end

  // Next-state logic; everything advances only on baud_tick.
  always_comb begin
    state_n  = state_q;
    cnt_n    = cnt_q;
    bit_n    = bit_q;
    shreg_n  = shreg_q;
    par_n    = par_q;
    par_en_n = par_en_q;
    stop_n   = stop_q;
    pend_n   = 1'b0;
    if (bus.baud_tick) begin
      case (state_q)
        IDLE: begin
          if (!rxd_s) begin
            state_n  = START;
            cnt_n    = '0;
            par_en_n = bus.parity_en;
            par_n    = 1'b0;
          end
        end
        START: begin
          if (cnt_q == CNT_MID) begin
            cnt_n   = '0;
            bit_n   = '0;
            state_n = rxd_s ? IDLE : DATA;
          end else begin
            cnt_n = cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (cnt_q == CNT_LAST) begin
            cnt_n   = '0;
            shreg_n = {rxd_s, shreg_q[DATA_WIDTH-1:1]};
            if (bit_q == BIT_LAST) begin
              bit_n   = '0;
              state_n = par_en_q ? PARITY : STOP;
            end else begin
              bit_n = bit_q + 1'b1;
            end
          end else begin
            cnt_n = cnt_q + 1'b1;
          end
        end
        PARITY: begin
          if (cnt_q == CNT_LAST) begin
            cnt_n   = '0;
            par_n   = rxd_s;
            state_n = STOP;
          end else begin
            cnt_n = cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (cnt_q == CNT_LAST) begin
            cnt_n   = '0;
            stop_n  = rxd_s;
            pend_n  = 1'b1;
            state_n = rxd_s ? IDLE : BREAK;
          end else begin
            cnt_n = cnt_q + 1'b1;
          end
        end
        BREAK: begin
          if (rxd_s) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign bus.data_in_parity = dout_q;
  assign bus.rx_valid       = valid_q;
  assign bus.framing_err    = ferr_q;
  assign bus.rx_busy        = busy_q;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer: 8 data bits, 16x oversampling, one baud_tick every 4 HCLK.
module tb_uart_rx_deserializer;

  logic HCLK;
  logic HRESETn;

  uart_rx_deserializer_if #(.DATA_WIDTH(8)) bus ();

  uart_rx_deserializer #(.DATA_WIDTH(8), .OVERSAMPLE(16)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  int checks     = 0;
  int failures   = 0;
  int tick_count = 0;
  int valid_cnt  = 0;
  int valid_tick = -1;
  logic [8:0] cap [0:15];

  // Records every rx_valid pulse with its payload and the baud tick it followed.
  always @(negedge HCLK) begin
    if (bus.rx_valid === 1'b1) begin
      cap[valid_cnt % 16] = bus.data_in_parity;
      valid_tick = tick_count;
      valid_cnt  = valid_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One baud_tick; returns on the falling edge right after the tick was consumed.
  task automatic tick();
    repeat (3) @(negedge HCLK);
    bus.baud_tick = 1'b1;
    tick_count++;
    @(negedge HCLK);
    bus.baud_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_frame(input logic [7:0] data, input logic par, input logic use_par,
                            input logic stop);
    bus.rxd = 1'b0;
    ticks(16);
    for (int i = 0; i < 8; i++) begin
      bus.rxd = data[i];
      ticks(16);
    end
    if (use_par) begin
      bus.rxd = par;
      ticks(16);
    end
    bus.rxd = stop;
    ticks(16);
  endtask

  int v0;
  int s0;
  logic [7:0] partial;

  initial begin
    HRESETn       = 1'b0;
    bus.rxd       = 1'b1;
    bus.baud_tick = 1'b0;
    bus.parity_en = 1'b0;
    partial       = 8'h5A;
    repeat (4) @(negedge HCLK);
    check("reset_data",  32'(bus.data_in_parity), 32'h000);
    check("reset_valid", 32'(bus.rx_valid),       32'h0);
    check("reset_ferr",  32'(bus.framing_err),    32'h0);
    check("reset_busy",  32'(bus.rx_busy),        32'h0);
    HRESETn = 1'b1;
    ticks(5);

    // Parity-enabled frame A5, parity 0, good stop.
    bus.parity_en = 1'b1;
    v0 = valid_cnt;
    send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
    check("a5_pulses", 32'(valid_cnt - v0),       32'd1);
    check("a5_data",   32'(bus.data_in_parity),   32'h0A5);
    check("a5_ferr",   32'(bus.framing_err),      32'h0);
    check("a5_busy",   32'(bus.rx_busy),          32'h0);
    check("a5_valid",  32'(bus.rx_valid),         32'h0);

    // Parity disabled, frame 3C, plus stop-sample-to-valid latency.
    bus.parity_en = 1'b0;
    v0 = valid_cnt;
    s0 = tick_count;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
    check("3c_pulses", 32'(valid_cnt - v0),       32'd1);
    check("3c_data",   32'(bus.data_in_parity),   32'h03C);
    check("3c_tick",   32'(valid_tick),           32'(s0 + 152));
    check("3c_ferr",   32'(bus.framing_err),      32'h0);

    // Glitch shorter than half a bit: start aborts, outputs unchanged.
    v0 = valid_cnt;
    bus.rxd = 1'b0;
    ticks(4);
    check("glitch_busy_mid", 32'(bus.rx_busy), 32'h1);
    bus.rxd = 1'b1;
    ticks(20);
    check("glitch_pulses", 32'(valid_cnt - v0),     32'd0);
    check("glitch_data",   32'(bus.data_in_parity), 32'h03C);
    check("glitch_ferr",   32'(bus.framing_err),    32'h0);
    check("glitch_busy",   32'(bus.rx_busy),        32'h0);

    // Bad stop bit followed by a held-low line: one frame, then break.
    bus.parity_en = 1'b1;
    v0 = valid_cnt;
    send_frame(8'hFF, 1'b0, 1'b1, 1'b0);
    ticks(48);
    check("brk_busy_low", 32'(bus.rx_busy),        32'h1);
    check("brk_pulses",   32'(valid_cnt - v0),     32'd1);
    check("brk_ferr",     32'(bus.framing_err),    32'h1);
    check("brk_data",     32'(bus.data_in_parity), 32'h0FF);
    bus.rxd = 1'b1;
    ticks(2);
    check("brk_busy_high",  32'(bus.rx_busy),    32'h0);
    check("brk_pulses_end", 32'(valid_cnt - v0), 32'd1);

    // Reset in the middle of data bit 4, then a clean frame 5A.
    bus.parity_en = 1'b0;
    v0 = valid_cnt;
    bus.rxd = 1'b0;
    ticks(16);
    for (int i = 0; i < 4; i++) begin
      bus.rxd = partial[i];
      ticks(16);
    end
    bus.rxd = partial[4];
    ticks(8);
    @(negedge HCLK);
    HRESETn = 1'b0;
    @(negedge HCLK);
    HRESETn = 1'b1;
    check("rst_data",  32'(bus.data_in_parity), 32'h000);
    check("rst_valid", 32'(bus.rx_valid),       32'h0);
    check("rst_ferr",  32'(bus.framing_err),    32'h0);
    check("rst_busy",  32'(bus.rx_busy),        32'h0);
    bus.rxd = 1'b1;
    ticks(20);
    check("rst_no_frame", 32'(valid_cnt - v0), 32'd0);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
    check("5a_pulses", 32'(valid_cnt - v0),     32'd1);
    check("5a_data",   32'(bus.data_in_parity), 32'h05A);
    check("5a_ferr",   32'(bus.framing_err),    32'h0);

    // Back-to-back frames with no idle gap.
    bus.parity_en = 1'b1;
    v0 = valid_cnt;
    send_frame(8'h01, 1'b0, 1'b1, 1'b1);
    send_frame(8'h80, 1'b1, 1'b1, 1'b1);
    check("b2b_pulses", 32'(valid_cnt - v0),     32'd2);
    check("b2b_first",  32'(cap[v0 % 16]),       32'h001);
    check("b2b_second", 32'(cap[(v0 + 1) % 16]), 32'h180);
    check("b2b_ferr",   32'(bus.framing_err),    32'h0);
    check("b2b_busy",   32'(bus.rx_busy),        32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_deserializer.md
UART_RX_DESERIALIZER -- requirements
Module: uart_rx_deserializer

Interface
REQ-001 Parameters SHALL be:
- DATA_WIDTH, default 8, number of data bits per frame excluding parity.
- OVERSAMPLE, default 16, baud_tick pulses per bit period; even value, at least 8.
REQ-002 HCLK  input  1  system clock; all state SHALL update on its rising edge only.
REQ-003 HRESETn  input  1  reset, synchronous and active-low.
REQ-004 baud_tick  input  1  single-HCLK enable pulse at OVERSAMPLE x baud rate.
REQ-005 rxd  input  1  asynchronous serial line; idle level is 1.
REQ-006 parity_en  input  1  1 = frame carries a parity bit after the data bits.
REQ-007 data_in_parity  output  DATA_WIDTH+1  received frame: data in [DATA_WIDTH-1:0], received parity bit in [DATA_WIDTH]; consumed by the downstream parity checker.
REQ-008 rx_valid  output  1  one-HCLK pulse marking data_in_parity and framing_err as newly valid.
REQ-009 framing_err  output  1  stop bit of the last frame was sampled as 0.
REQ-010 rx_busy  output  1  frame reception in progress.

Function
REQ-011 rxd SHALL pass through a 2-flop synchronizer whose flops reset to 1; all further logic SHALL use only the synchronized value, rxd_s.
REQ-012 The FSM SHALL have the states IDLE, START, DATA, PARITY, STOP and BREAK, plus a tick counter that wraps modulo OVERSAMPLE.
REQ-013 Every FSM and counter transition SHALL occur only on HCLK cycles where baud_tick=1.
REQ-014 IDLE -> START on baud_tick with rxd_s=0.
- The tick counter SHALL clear on this transition.
- parity_en SHALL be latched here and held for the whole frame.
REQ-015 In START, on the tick that brings the counter to OVERSAMPLE/2-1:
- rxd_s=0 -> DATA, counter cleared;
- rxd_s=1 -> IDLE (false start): no rx_valid, no output change.
REQ-016 In DATA, the bit SHALL be sampled each time the counter reaches OVERSAMPLE-1.
- Bits SHALL shift in LSB first.
- After DATA_WIDTH bits: -> PARITY if latched parity_en=1, else -> STOP.
REQ-017 In PARITY, one bit SHALL be sampled at counter OVERSAMPLE-1 into bit [DATA_WIDTH], then -> STOP.
- When parity is disabled, bit [DATA_WIDTH] SHALL be 0.
REQ-018 In STOP, rxd_s SHALL be sampled at counter OVERSAMPLE-1.
- On the next HCLK edge: data_in_parity loads, framing_err = ~stop sample, and rx_valid=1 for exactly one cycle.
- Next state: IDLE if the stop sample was 1, BREAK if it was 0.
REQ-019 BREAK SHALL be left for IDLE only on a baud_tick with rxd_s=1, so that a held-low line yields exactly one frame with framing_err=1.
REQ-020 Outputs SHALL hold between rx_valid pulses.
- framing_err SHALL update only with rx_valid.
REQ-021 rx_busy SHALL be 1 in START, DATA, PARITY, STOP and BREAK, and 0 in IDLE.
REQ-022 No backpressure: a frame completing while the previous one is unconsumed SHALL overwrite it.
REQ-023 rxd activity between baud_ticks SHALL be ignored.

Reset
REQ-024 With HRESETn=0 at an HCLK edge:
- FSM -> IDLE, counter = 0, shift register = 0, synchronizer flops = 1;
- data_in_parity = 0, rx_valid = 0, framing_err = 0, rx_busy = 0.
REQ-025 Reset mid-frame SHALL discard the partial frame with no rx_valid.
- A frame SHALL be accepted only after a new falling edge following reset release.

Verification
REQ-026 Parity enabled; frame 0, 8'hA5 LSB first, parity bit 0, stop 1 -> one rx_valid pulse, data_in_parity = 9'h0A5, framing_err = 0, rx_busy = 0 afterwards.
REQ-027 Parity disabled; frame 8'h3C with stop 1 -> data_in_parity = 9'h03C.
- rx_valid follows the stop-bit sample tick by one HCLK.
- The stop-bit sample tick is (OVERSAMPLE/2-1) + 9*OVERSAMPLE ticks after the start detect.
REQ-028 rxd low for 4 baud_ticks, then high -> START aborts to IDLE; no rx_valid; outputs unchanged.
REQ-029 Frame 8'hFF, parity 0, stop bit 0, line then held low for 3 bit times -> exactly one rx_valid with framing_err = 1 and data_in_parity = 9'h0FF.
- rx_busy stays 1 until rxd returns high.
REQ-030 HRESETn pulsed low during data bit 4 -> all outputs at reset values next cycle.
- The next full frame 8'h5A, parity 0, is received correctly as 9'h05A.
REQ-031 Two back-to-back frames, 8'h01 then 8'h80, with no idle gap -> two rx_valid pulses, carrying 9'h001 then 9'h180 (parity bit 1 in the second frame).
